aes_cipher_hs: RTL and testbench

Iterative AES-128 encryption engine: the forward-direction counterpart of the team's iterative inverse cipher, sharing its byte ordering and round-per-cycle architecture. The block holds a cipher key, accepts plaintext blocks over a valid/ready handshake, runs the 10 AES rounds one per clock and computes the round keys on the fly. Ciphertext is returned on a valid/ready handshake. The block sits between the packet datapath and the link-side framer.

---
 rtl/aes_cipher_hs_if.sv | 26 ++
 rtl/aes_cipher_hs.sv | 188 ++++++++++++++++++
 tb/tb_aes_cipher_hs.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cipher_hs_if.sv
// Handshake bundle for aes_cipher_hs.
// master: key/plaintext source and ciphertext consumer.
// slave:  the cipher engine.
// Signals: key_ld/key (key load), in_vld/in_rdy/text_in (plaintext),
//          out_vld/out_rdy/text_out (ciphertext), busy (RUN or DONE).
interface aes_cipher_hs_if;
  logic         key_ld;
  logic [127:0] key;
  logic         in_vld;
  logic         in_rdy;
  logic [127:0] text_in;
  logic         out_vld;
  logic         out_rdy;
  logic [127:0] text_out;
  logic         busy;

  modport master (
    output key_ld, key, in_vld, text_in, out_rdy,
    input  in_rdy, out_vld, text_out, busy
  );

  modport slave (
    input  key_ld, key, in_vld, text_in, out_rdy,
    output in_rdy, out_vld, text_out, busy
  );
endinterface

// File: rtl/aes_cipher_hs.sv
// Iterative AES-128 encryption engine, one round per clock, round keys
// expanded on the fly.
// Ports: clk, rst (synchronous, active-high), bus (aes_cipher_hs_if.slave):
//   key_ld/key load the cipher key in IDLE; in_vld/in_rdy/text_in accept a
//   plaintext block; out_vld/out_rdy/text_out return the ciphertext;
//   busy is high in RUN and DONE. Byte 0 of every 128-bit word is [127:120].

// Forward AES S-box lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = SBOX_TBL[8*(255-i) +: 8];
  end

  assign y = rom[a];
endmodule

module aes_cipher_hs (
  input  logic            clk,
  input  logic            rst,
  aes_cipher_hs_if.slave  bus
);
  localparam int unsigned NB = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] key_reg;
  logic [127:0] rk;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic         in_rdy;
  logic         out_vld;
  logic         busy;

  logic [7:0]   sb [NB];
  logic [7:0]   sr [NB];
  logic [7:0]   mc [NB];
  logic [127:0] round_out;
  logic [127:0] rk_next;
  logic [127:0] k0;
  logic [7:0]   rcon;
  logic [31:0]  key_rot;
  logic [31:0]  key_sub;
  logic [31:0]  kt;
  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;
  logic         last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for the round being computed this cycle.
  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Key expansion step: RotWord, SubWord, rcon, chained word XOR.
  assign key_rot = {rk[23:0], rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_ksb
    aes_sbox u_ksb (.a(key_rot[8*i +: 8]), .y(key_sub[8*i +: 8]));
  end

  assign kt      = key_sub ^ {rcon, 24'h000000};
  assign w0      = rk[127:96] ^ kt;
  assign w1      = rk[95:64]  ^ w0;
  assign w2      = rk[63:32]  ^ w1;
  assign w3      = rk[31:0]   ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  // SubBytes on the 16 state bytes.
  for (genvar i = 0; i < NB; i++) begin : g_ssb
    aes_sbox u_ssb (.a(st[8*(15-i) +: 8]), .y(sb[i]));
  end

  // ShiftRows: row r rotates left by r; byte index is 4*col + row.
  for (genvar c = 0; c < 4; c++) begin : g_sr_col
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  // MixColumns in xtime form: b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3).
  for (genvar c = 0; c < 4; c++) begin : g_mc_col
    for (genvar r = 0; r < 4; r++) begin : g_mc_row
      assign mc[4*c+r] = xt(sr[4*c+r]) ^ xt(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                       ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
    end
  end

  // Final round skips MixColumns.
  assign last = (rnd == 4'd10);

  for (genvar i = 0; i < NB; i++) begin : g_ark
    assign round_out[8*(15-i) +: 8] = (last ? sr[i] : mc[i]) ^ rk_next[8*(15-i) +: 8];
  end

  // A key loaded in the accept cycle applies to that same block.
  assign k0 = bus.key_ld ? bus.key : key_reg;

  // Control FSM with key, round-key and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      key_reg <= '0;
      rk      <= '0;
      st      <= '0;
      rnd     <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.key_ld) key_reg <= bus.key;
          if (bus.in_vld) begin
            rk     <= k0;
            st     <= bus.text_in ^ k0;
            rnd    <= 4'd1;
            fsm    <= RUN;
            in_rdy <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          rk  <= rk_next;
          st  <= round_out;
          rnd <= 4'(rnd + 4'd1);
          if (last) begin
            fsm     <= DONE;
            out_vld <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            fsm     <= IDLE;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          fsm     <= IDLE;
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = out_vld;
  assign bus.busy     = busy;
  assign bus.text_out = st;
endmodule

// File: tb/tb_aes_cipher_hs.sv
// Bench for aes_cipher_hs: a byte-level AES-128 reference (full key
// expansion, S-box derived from the GF(2^8) inverse and affine map) plus a
// transaction-level handshake model, compared with the DUT every cycle.
module tb_aes_cipher_hs;
  logic clk;
  logic rst;
  aes_cipher_hs_if bus ();

  aes_cipher_hs dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ABK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ABP = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ABC = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] sbox_t [256];

  // Handshake model state.
  bit           m_valid = 1'b0;
  bit           m_idle  = 1'b1;
  bit           m_done  = 1'b0;
  int           m_left  = 0;
  logic [127:0] m_key   = '0;
  logic [127:0] m_out   = '0;
  logic [127:0] m_exp   = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tw;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox_t[tw[31:24]], sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]]}
             ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int n = 1; n <= 10; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (n < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*n+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Transaction model: advances on each rising edge from the driven inputs.
  initial forever begin
    logic [127:0] k_eff;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 1'b1;
      m_idle  = 1'b1;
      m_done  = 1'b0;
      m_left  = 0;
      m_key   = '0;
      m_out   = '0;
    end else if (m_valid) begin
      if (m_idle) begin
        k_eff = bus.key_ld ? bus.key : m_key;
        if (bus.key_ld) m_key = bus.key;
        if (bus.in_vld) begin
          m_exp  = aes_ref(k_eff, bus.text_in);
          m_idle = 1'b0;
          m_left = 10;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_out  = m_exp;
        end
      end else if (m_done && bus.out_rdy) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("in_rdy", 128'(bus.in_rdy), 128'(m_idle));
      chk("out_vld", 128'(bus.out_vld), 128'(m_done));
      chk("busy", 128'(bus.busy), 128'(!m_idle));
      if (m_idle || m_done) chk("text_out", bus.text_out, m_out);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input bit ld, input logic [127:0] k, input logic [127:0] p);
    int n;
    n = 0;
    bus.key_ld  = ld;
    bus.key     = k;
    bus.text_in = p;
    bus.in_vld  = 1'b1;
    while (!bus.in_rdy && n < 40) begin
      step();
      n++;
    end
    chk("send_in_rdy_timeout", 128'(bus.in_rdy), 128'(1));
    step();
    bus.in_vld  = 1'b0;
    bus.key_ld  = 1'b0;
    bus.text_in = r128();
  endtask

  task automatic junk();
    bus.in_vld  = 1'($urandom_range(0, 1));
    bus.key_ld  = 1'($urandom_range(0, 1));
    bus.key     = r128();
    bus.text_in = r128();
  endtask

  // Waits for out_vld, optionally stalls out_rdy, then takes the result.
  task automatic recv(input int hold, input bit noise, input bit bp_chk,
                      output logic [127:0] ct, output int lat);
    lat = 0;
    while (!bus.out_vld && lat < 40) begin
      if (noise) junk();
      step();
      lat++;
    end
    chk("recv_out_vld_timeout", 128'(bus.out_vld), 128'(1));
    ct = bus.text_out;
    for (int i = 0; i < hold; i++) begin
      if (noise) junk();
      step();
      if (bp_chk) begin
        chk("bp_text_out_stable", bus.text_out, ct);
        chk("bp_in_rdy_low", 128'(bus.in_rdy), 128'(0));
        chk("bp_out_vld_held", 128'(bus.out_vld), 128'(1));
      end
    end
    bus.in_vld  = 1'b0;
    bus.key_ld  = 1'b0;
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
  endtask

  initial begin
    logic [127:0] ct;
    int           lat;
    int           t0;
    int           t1;
    int           n;
    bit           seen;

    rst         = 1'b1;
    bus.key_ld  = 1'b0;
    bus.key     = '0;
    bus.in_vld  = 1'b0;
    bus.text_in = '0;
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

    // Pin the reference against published vectors.
    chk("ref_sbox_00", 128'(sbox_t[0]), 128'h63);
    chk("ref_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    chk("ref_c1", aes_ref(C1K, C1P), C1C);
    chk("ref_appb", aes_ref(ABK, ABP), ABC);
    chk("ref_zero", aes_ref('0, '0), ZC);

    do_reset();
    chk("rst_in_rdy", 128'(bus.in_rdy), 128'(1));
    chk("rst_out_vld", 128'(bus.out_vld), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_text_out", bus.text_out, '0);

    // Zero key straight after reset.
    send(1'b0, r128(), '0);
    recv(0, 1'b0, 1'b0, ct, lat);
    chk("zero_key_ct", ct, ZC);
    chk("zero_key_latency", 128'(lat), 128'(10));

    // C.1 with the key loaded ahead of the accept.
    bus.key_ld = 1'b1;
    bus.key    = C1K;
    step();
    bus.key_ld = 1'b0;
    send(1'b0, r128(), C1P);
    recv(0, 1'b0, 1'b0, ct, lat);
    chk("c1_ct", ct, C1C);
    chk("c1_latency", 128'(lat), 128'(10));

    // App. B with key load coinciding with the accept.
    send(1'b1, ABK, ABP);
    recv(2, 1'b0, 1'b0, ct, lat);
    chk("appb_ct", ct, ABC);

    // Backpressure for 20 cycles with noisy in_vld/key_ld.
    bus.key_ld = 1'b1;
    bus.key    = C1K;
    step();
    bus.key_ld = 1'b0;
    send(1'b0, r128(), C1P);
    recv(20, 1'b1, 1'b1, ct, lat);
    chk("bp_ct", ct, C1C);
    send(1'b0, r128(), C1P);
    recv(0, 1'b0, 1'b0, ct, lat);
    chk("bp_key_held_ct", ct, C1C);

    // Back-to-back blocks with in_vld and out_rdy held high.
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1;
    bus.text_in = C1P;
    n = 0;
    while (!bus.in_rdy && n < 40) begin step(); n++; end
    step();
    t0 = cyc;
    bus.text_in = '0;
    n = 0;
    while (!bus.in_rdy && n < 40) begin step(); n++; end
    step();
    t1 = cyc;
    bus.in_vld = 1'b0;
    chk("b2b_period", 128'(t1 - t0), 128'(12));
    n = 0;
    while (!bus.out_vld && n < 40) begin step(); n++; end
    chk("b2b_second_ct", bus.text_out, aes_ref(C1K, '0));
    step();
    bus.out_rdy = 1'b0;

    // Randomized blocks, key loads, gaps and stalls.
    for (int it = 0; it < 16; it++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.key_ld = 1'($urandom_range(0, 1));
        bus.key    = r128();
        step();
      end
      bus.key_ld = 1'b0;
      send(1'($urandom_range(0, 1)), r128(), r128());
      recv(int'($urandom_range(0, 4)), 1'b1, 1'b0, ct, lat);
      chk("rand_latency", 128'(lat), 128'(10));
    end

    // Reset in the middle of a block.
    send(1'b1, r128(), r128());
    repeat (4) step();
    rst  = 1'b1;
    seen = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_in_rdy", 128'(bus.in_rdy), 128'(1));
    chk("midrst_text_out", bus.text_out, '0);
    repeat (15) begin
      if (bus.out_vld) seen = 1'b1;
      step();
    end
    chk("midrst_no_out_vld", 128'(seen), 128'(0));
    send(1'b0, r128(), '0);
    recv(0, 1'b0, 1'b0, ct, lat);
    chk("midrst_zero_key_ct", ct, ZC);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
